sevenseg_scan: RTL and testbench

Multiplexed 8-digit seven-segment driver that sits directly downstream of the 32-bit display-select mux. It captures the selected 32-bit `display` word into a shadow register and scans it out as eight hex digits on a shared segment bus with one-hot anodes. It also provides optional leading-zero blanking and a decimal-point "value changed" flash on digit 0.

---
 rtl/sevenseg_pkg.sv | 16 +
 rtl/sevenseg_hex7seg.sv | 11 +
 rtl/sevenseg_scan.sv | 93 +++++++++
 tb/tb_sevenseg_scan.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: the hex glyph table
// and the all-off codes for the segment and anode buses.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/sevenseg_hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// 8-digit multiplexed seven-segment driver with shadow capture, leading-zero
// blanking and a decimal-point flash on digit 0 after the shown value changes.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int FLASH_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display,
    input  logic        hold,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               PRE_W      = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
    localparam logic [7:0]       FLASH_LOAD = 8'(FLASH_FRAMES);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       flash_cnt_q, flash_cnt_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic [31:0]      upper;
    logic             blank;

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_comb begin
        tick      = (pre_cnt_q == PRE_MAX);
        frame_end = tick && (idx_q == 3'd7);

        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
        idx_d     = tick ? idx_q + 3'd1 : idx_q;
        shadow_d  = hold ? shadow_q : display;

        // A fresh change always restarts the flash, even on a frame boundary.
        flash_cnt_d = flash_cnt_q;
        if (!hold && (display != shadow_q)) begin
            flash_cnt_d = FLASH_LOAD;
        end else if (frame_end && (flash_cnt_q != 8'd0)) begin
            flash_cnt_d = flash_cnt_q - 8'd1;
        end

        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        upper  = shadow_q >> {idx_q, 2'b00};
        blank  = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);

        an_d  = ~(8'b1 << idx_q);
        seg_d = blank ? SEG_BLANK : glyph;
        dp_d  = !((idx_q == 3'd0) && (flash_cnt_q != 8'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q   <= '0;
            idx_q       <= 3'd0;
            shadow_q    <= 32'd0;
            flash_cnt_q <= 8'd0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            flash_cnt_q <= flash_cnt_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed self-checking bench for sevenseg_scan with CLK_DIV=4, FLASH_FRAMES=2.
module tb_sevenseg_scan;

    localparam int CLK_DIV      = 4;
    localparam int FLASH_FRAMES = 2;
    localparam int FRAME        = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] display;
    logic        hold;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    sevenseg_scan #(
        .CLK_DIV      (CLK_DIV),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .display  (display),
        .hold     (hold),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Edges since reset release; at a negedge, cycle c shows slot (c-1)/CLK_DIV.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] an_exp(input int d);
        return ~(8'b1 << d);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to the first negedge on which digit d is shown.
    task automatic wait_digit(input int d);
        int n;
        n = 0;
        step();
        while (!((cyc >= 1) && (((cyc - 1) % FRAME) == d * CLK_DIV)) && (n < 2 * FRAME)) begin
            step();
            n++;
        end
        if (n >= 2 * FRAME) begin
            tests++;
            fails++;
            $display("FAIL wait_digit%0d: slot not reached, cyc=%0d", d, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; display = 32'h0; hold = 1'b0; blank_lz = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        display = 32'h1234_5678;
        repeat (10) step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_async: an/seg/dp got %h/%h/%b expected ff/7f/1", an, seg, dp);
        end
        step();
        tests++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_held: an/seg/dp got %h/%h/%b expected ff/7f/1", an, seg, dp);
        end
        display = 32'h0;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        for (int k = 1; k <= 36; k++) begin
            step();
            tests++;
            if (an !== an_exp(((k - 1) / CLK_DIV) % 8)) begin
                fails++;
                $display("FAIL scan_an cycle %0d: got %h expected %h", k, an, an_exp(((k - 1) / CLK_DIV) % 8));
            end
            tests++;
            if (seg !== 7'h40 || dp !== 1'b1) begin
                fails++;
                $display("FAIL scan_seg cycle %0d: got seg %h dp %b expected 40 1", k, seg, dp);
            end
        end
    endtask

    task automatic test_decode();
        logic [6:0] exp_dec [8];
        exp_dec = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        display = 32'h89AB_CDEF;
        step(); step();
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            tests++;
            if (an !== an_exp(d) || seg !== exp_dec[d]) begin
                fails++;
                $display("FAIL decode digit %0d: got an %h seg %h expected %h %h", d, an, seg, an_exp(d), exp_dec[d]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] exp_a [8];
        logic [6:0] exp_z [8];
        exp_a = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        exp_z = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        blank_lz = 1'b1;
        display  = 32'h0000_0A05;
        step(); step();
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            tests++;
            if (an !== an_exp(d) || seg !== exp_a[d]) begin
                fails++;
                $display("FAIL blank_a05 digit %0d: got an %h seg %h expected %h %h", d, an, seg, an_exp(d), exp_a[d]);
            end
        end
        display = 32'h0;
        step(); step();
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            tests++;
            if (an !== an_exp(d) || seg !== exp_z[d]) begin
                fails++;
                $display("FAIL blank_zero digit %0d: got an %h seg %h expected %h %h", d, an, seg, an_exp(d), exp_z[d]);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_hold();
        display = 32'h1;
        repeat (4 * FRAME) step();
        hold = 1'b1;
        step();
        display = 32'h2;
        for (int f = 0; f < 3; f++) begin
            wait_digit(0);
            tests++;
            if (seg !== 7'h79 || dp !== 1'b1) begin
                fails++;
                $display("FAIL hold_frozen frame %0d: got seg %h dp %b expected 79 1", f, seg, dp);
            end
        end
        wait_digit(0);
        hold = 1'b0;
        step();
        tests++;
        if (seg !== 7'h79) begin
            fails++;
            $display("FAIL hold_release_1: got seg %h expected 79", seg);
        end
        step();
        tests++;
        if (seg !== 7'h24 || dp !== 1'b0) begin
            fails++;
            $display("FAIL hold_release_2: got seg %h dp %b expected 24 0", seg, dp);
        end
    endtask

    task automatic test_flash();
        display = 32'h0;
        repeat (4 * FRAME) step();
        wait_digit(0);
        display = 32'h5;
        step();
        tests++;
        if (dp !== 1'b1) begin
            fails++;
            $display("FAIL flash_first: got dp %b expected 1", dp);
        end
        for (int c = 2; c < CLK_DIV; c++) begin
            step();
            tests++;
            if (dp !== 1'b0 || seg !== 7'h12) begin
                fails++;
                $display("FAIL flash_load cycle %0d: got dp %b seg %h expected 0 12", c, dp, seg);
            end
        end
        for (int f = 1; f <= 3; f++) begin
            wait_digit(0);
            for (int c = 0; c < CLK_DIV; c++) begin
                tests++;
                if (dp !== (f == 1 ? 1'b0 : 1'b1)) begin
                    fails++;
                    $display("FAIL flash_frame %0d cycle %0d: got dp %b expected %b", f, c, dp, (f == 1 ? 1'b0 : 1'b1));
                end
                if (c < CLK_DIV - 1) step();
            end
            wait_digit(1);
            tests++;
            if (dp !== 1'b1) begin
                fails++;
                $display("FAIL flash_digit1 frame %0d: got dp %b expected 1", f, dp);
            end
        end
    endtask

    task automatic test_back_to_back();
        wait_digit(0);
        display = 32'h6;
        wait_digit(0);
        tests++;
        if (dp !== 1'b0) begin
            fails++;
            $display("FAIL b2b_setup: got dp %b expected 0", dp);
        end
        wait_digit(7);
        step(); step();
        display = 32'h7;
        for (int f = 0; f < 3; f++) begin
            wait_digit(0);
            tests++;
            if (dp !== (f < 2 ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL frame_end_reload frame %0d: got dp %b expected %b", f, dp, (f < 2 ? 1'b0 : 1'b1));
            end
        end
    endtask

    task automatic test_wrap();
        int lows [8];
        wait_digit(0);
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 8; i++) lows[i] = 0;
            for (int c = 0; c < FRAME; c++) begin
                if ((c % 7) == 3) hold = ~hold;
                tests++;
                if (an !== an_exp(c / CLK_DIV) || $countones(~an) != 1) begin
                    fails++;
                    $display("FAIL wrap_an frame %0d cycle %0d: got %h expected %h", f, c, an, an_exp(c / CLK_DIV));
                end
                for (int i = 0; i < 8; i++) if (an[i] === 1'b0) lows[i]++;
                step();
            end
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (lows[i] != CLK_DIV) begin
                    fails++;
                    $display("FAIL wrap_lowcount frame %0d anode %0d: got %0d expected %0d", f, i, lows[i], CLK_DIV);
                end
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_blanking();
        test_hold();
        test_flash();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
